// File: rtl/phys_regfile_rdy.sv
`default_nettype none
// ============================================================================
// Module   : phys_regfile_rdy
// Brief    : Multi-port physical register file with per-register ready bits,
//            same-cycle writeback bypass and a registered ready population count.
// Revision : 1.0 - initial release
// ============================================================================
module phys_regfile_rdy #(
    parameter int DATA_W    = 32,
    parameter int NUM_REGS  = 64,
    parameter int IDX_W     = 6,
    parameter int NUM_RD    = 3,
    parameter int NUM_WR    = 2,
    parameter int NUM_ALLOC = 1,
    parameter int NUM_ARCH  = 32,
    parameter int ZERO_HARD = 1
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        stall,
    input  logic [NUM_RD*IDX_W-1:0]     rd_idx,
    output logic [NUM_RD*DATA_W-1:0]    rd_data,
    output logic [NUM_RD-1:0]           rd_ready,
    input  logic [NUM_WR-1:0]           wr_en,
    input  logic [NUM_WR*IDX_W-1:0]     wr_idx,
    input  logic [NUM_WR*DATA_W-1:0]    wr_data,
    input  logic [NUM_ALLOC-1:0]        alloc_en,
    input  logic [NUM_ALLOC*IDX_W-1:0]  alloc_idx,
    output logic [IDX_W:0]              ready_count
);

    localparam logic [IDX_W:0] c_num_regs  = (IDX_W+1)'(NUM_REGS);
    localparam logic [IDX_W:0] c_num_arch  = (IDX_W+1)'(NUM_ARCH);
    localparam logic           c_zero_hard = (ZERO_HARD != 0);

    logic [DATA_W-1:0]   r_data [NUM_REGS];
    logic [NUM_REGS-1:0] r_ready;
    logic [IDX_W:0]      r_ready_count;
    logic [NUM_REGS-1:0] w_ready_nxt;
    logic [IDX_W:0]      w_ready_pop;

    function automatic logic f_in_range(input logic [IDX_W-1:0] idx);
        return {1'b0, idx} < c_num_regs;
    endfunction

    // Targets that may actually change state: in range and not the hardwired zero.
    function automatic logic f_updatable(input logic [IDX_W-1:0] idx);
        return f_in_range(idx) && !(c_zero_hard && idx == '0);
    endfunction

    // ------------------------------------------------------------------------
    // Read ports: zero register, out-of-range, bypass, then array
    // ------------------------------------------------------------------------
    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [IDX_W-1:0]  w_idx;
        logic [DATA_W-1:0] w_data;
        logic              w_rdy;

        assign w_idx = rd_idx[k*IDX_W +: IDX_W];

        always_comb begin
            w_data = '0;
            w_rdy  = 1'b0;
            if (c_zero_hard && w_idx == '0) begin
                w_rdy = 1'b1;
            end else if (f_in_range(w_idx)) begin
                w_data = r_data[w_idx];
                w_rdy  = r_ready[w_idx];
                if (!stall) begin
                    // Ascending scan so the highest matching write port wins.
                    for (int j = 0; j < NUM_WR; j++) begin
                        if (wr_en[j] && wr_idx[j*IDX_W +: IDX_W] == w_idx) begin
                            w_data = wr_data[j*DATA_W +: DATA_W];
                            w_rdy  = 1'b1;
                        end
                    end
                end
            end
        end

        assign rd_data[k*DATA_W +: DATA_W] = w_data;
        assign rd_ready[k]                 = w_rdy;
    end

    // ------------------------------------------------------------------------
    // Next-state ready vector: writes set, allocs clear afterwards (alloc wins)
    // ------------------------------------------------------------------------
    always_comb begin
        w_ready_nxt = r_ready;
        if (!stall) begin
            for (int j = 0; j < NUM_WR; j++) begin
                if (wr_en[j] && f_updatable(wr_idx[j*IDX_W +: IDX_W])) begin
                    w_ready_nxt[wr_idx[j*IDX_W +: IDX_W]] = 1'b1;
                end
            end
            for (int a = 0; a < NUM_ALLOC; a++) begin
                if (alloc_en[a] && f_updatable(alloc_idx[a*IDX_W +: IDX_W])) begin
                    w_ready_nxt[alloc_idx[a*IDX_W +: IDX_W]] = 1'b0;
                end
            end
        end
        if (c_zero_hard) begin
            w_ready_nxt[0] = 1'b1;
        end
    end

    always_comb begin
        w_ready_pop = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            w_ready_pop = w_ready_pop + (IDX_W+1)'(w_ready_nxt[i]);
        end
    end

    // ------------------------------------------------------------------------
    // State update
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_data[i]  <= '0;
                r_ready[i] <= (i < NUM_ARCH) || (c_zero_hard && i == 0);
            end
            r_ready_count <= c_num_arch;
        end else begin
            if (!stall) begin
                for (int j = 0; j < NUM_WR; j++) begin
                    if (wr_en[j] && f_updatable(wr_idx[j*IDX_W +: IDX_W])) begin
                        r_data[wr_idx[j*IDX_W +: IDX_W]] <= wr_data[j*DATA_W +: DATA_W];
                    end
                end
            end
            r_ready       <= w_ready_nxt;
            r_ready_count <= w_ready_pop;
        end
    end

    assign ready_count = r_ready_count;

endmodule
`default_nettype wire

// File: doc/phys_regfile_rdy.md
Name: phys_regfile_rdy

Overview:
- Parametrised successor to the single-write physical register file in the out-of-order core.
- Adds N read ports, M write ports and a per-register ready (scoreboard) bit.
- Write ports come from the CDB/writeback lanes; allocation clears ready bits at rename.
- Reads forward same-cycle writeback data and set ready, so issue logic sees results without a bubble.

Parameters:
- DATA_W, 32, register data width in bits.
- NUM_REGS, 64, number of physical registers.
- IDX_W, 6, index width; must satisfy 2^IDX_W >= NUM_REGS.
- NUM_RD, 3, number of read ports.
- NUM_WR, 2, number of write (writeback) ports.
- NUM_ALLOC, 1, number of rename allocation ports.
- NUM_ARCH, 32, registers 0..NUM_ARCH-1 are ready after reset (initial identity mapping).
- ZERO_HARD, 1, if 1 then register 0 always reads 0 and ready; writes and allocs to it are ignored.

Ports:
- clk, in, 1, clock; all state updates on the rising edge.
- reset, in, 1, synchronous active-high reset.
- stall, in, 1, when 1, all writes and allocs this cycle are dropped and bypass is disabled.
- rd_idx, in, NUM_RD*IDX_W, read indices; port k occupies bits [k*IDX_W +: IDX_W].
- rd_data, out, NUM_RD*DATA_W, read data per port.
- rd_ready, out, NUM_RD, ready bit per read port.
- wr_en, in, NUM_WR, write enable per port.
- wr_idx, in, NUM_WR*IDX_W, write indices.
- wr_data, in, NUM_WR*DATA_W, write data.
- alloc_en, in, NUM_ALLOC, allocation enable; clears the ready bit of alloc_idx.
- alloc_idx, in, NUM_ALLOC*IDX_W, allocated destination register indices.
- ready_count, out, IDX_W+1, registered population count of ready bits.

Behaviour:
- Storage: data array NUM_REGS x DATA_W and ready vector NUM_REGS.
- Reset (sync, takes priority over everything, including stall):
  - all data cleared to 0.
  - ready[i] = 1 for i < NUM_ARCH, 0 otherwise.
  - ready_count = NUM_ARCH.
  - Reset asserted mid-operation discards that cycle's writes and allocs.
- Reads are combinational, zero latency, for each port k:
  - If ZERO_HARD and rd_idx==0: data=0, ready=1.
  - Else, if !stall and any wr_en[j] with wr_idx[j]==rd_idx: data=wr_data of the highest such j, ready=1 (bypass).
  - Else: data=array[rd_idx], ready=ready[rd_idx].
  - Bypass does not consider same-cycle alloc. A read of a register being allocated returns the pre-edge ready value.
- Write, on the edge when !stall and !reset:
  - For each j with wr_en[j]: array[wr_idx[j]] <= wr_data[j] and ready <= 1.
  - Two write ports with the same index: the highest port index wins the data.
- Alloc, on the edge when !stall and !reset:
  - For each alloc_en[a]: ready[alloc_idx[a]] <= 0. Data is unchanged.
  - Alloc and write to the same index in the same cycle: data is written, ready ends 0 (alloc wins).
- Out-of-range indices (>= NUM_REGS): writes and allocs are ignored; reads return 0 with ready 0.
- stall=1: array and ready vector hold; bypass is off.
- ready_count:
  - Registered; equals popcount(ready) after each edge, so it is valid one cycle after the update.
  - With ZERO_HARD, register 0 counts as ready.
- No other internal state. No combinational path exists from the write ports to ready_count.

Test Plan:
1. Reset, then read idx 5 and idx 40 -> rd_data 0/0; rd_ready 1/0; ready_count=32 next cycle.
2. Write port0 idx 40 = 0xDEADBEEF while reading idx 40 the same cycle -> rd_data 0xDEADBEEF, rd_ready 1 via bypass. Next cycle, with no write, the same value comes from the array; ready_count=33.
3. Both write ports target idx 7 with 0x11 (port0) and 0x22 (port1) -> same-cycle read shows 0x22; next cycle 0x22, ready 1.
4. Alloc idx 7 and write idx 7 = 0x33 in the same cycle -> next cycle read 0x33 with ready 0; a later write 0x44 gives 0x44 with ready 1.
5. stall=1 with write idx 50 = 0x55 and alloc idx 3 -> same-cycle read of 50 shows the old value, no bypass. After the edge, idx 50 is unchanged and ready[3] is still 1.
6. ZERO_HARD=1: write idx 0 = 0xFF and alloc idx 0 -> reads of idx 0 always return 0 and ready 1. Also assert reset in the same cycle as a write to idx 9 -> idx 9 reads 0 afterwards.
